wimax_deinterleaver: RTL

Receive-side block-deinterleaver for the WiMAX PHY (QPSK, rate-1/2 profile: N_CBPS = 192, d = 16). It undoes the transmit interleaver permutation, taking hard-decision bits from the demapper and delivering them in encoder order to the Viterbi decoder. It uses ping-pong bit banks so that one block can be written while the previous block is read, sustaining 1 bit/cycle in both directions. Bit-serial valid/ready handshake on both sides, in the 100 MHz domain.

---
 rtl/wimax_deinterleaver_pkg.sv | 27 ++
 rtl/wimax_deint_addr_gen.sv | 47 ++++
 rtl/wimax_deinterleaver.sv | 79 +++++++
 3 files changed

// File: rtl/wimax_deinterleaver_pkg.sv
// Shared constants and reference vectors for the WiMAX QPSK rate-1/2 deinterleaver.
// INTERLEAVER_OUTPUT is derived from FEC_ENDODER_OUTPUT via the transmit permutation.
package wimax_deinterleaver_pkg;

  localparam int WIMAX_NCBPS = 192;
  localparam int WIMAX_D     = 16;
  localparam int WIMAX_AW    = $clog2(WIMAX_NCBPS);

  // Transmit-side permutation: encoder bit k lands at position m_k = rows*(k mod d) + floor(k/d).
  // Vectors are MSB-first in stream order, so stream index i lives at bit NCBPS-1-i.
  function automatic logic [WIMAX_NCBPS-1:0] wimax_interleave(input logic [WIMAX_NCBPS-1:0] enc);
    logic [WIMAX_NCBPS-1:0] ilv;
    int m;
    ilv = '0;
    for (int k = 0; k < WIMAX_NCBPS; k++) begin
      m = (WIMAX_NCBPS / WIMAX_D) * (k % WIMAX_D) + k / WIMAX_D;
      ilv[WIMAX_AW'(WIMAX_NCBPS - 1 - m)] = enc[WIMAX_AW'(WIMAX_NCBPS - 1 - k)];
    end
    return ilv;
  endfunction

  localparam logic [WIMAX_NCBPS-1:0] FEC_ENDODER_OUTPUT =
    192'h2b3f_91c4_7e05_d8a6_13f7_c29b_5e60_8a4d_f1b2_3c97_e46a_05d8;

  localparam logic [WIMAX_NCBPS-1:0] INTERLEAVER_OUTPUT = wimax_interleave(FEC_ENDODER_OUTPUT);

endpackage

// File: rtl/wimax_deint_addr_gen.sv
// Write-side address generator: row/column counters map received index j to bank address.
// block_done pulses combinationally on the transfer of the last bit of a block.
module wimax_deint_addr_gen
  import wimax_deinterleaver_pkg::*;
#(
  parameter int N_CBPS = WIMAX_NCBPS,
  parameter int N_D    = WIMAX_D
) (
  input  logic                      clk,
  input  logic                      reset_N,
  input  logic                      advance,
  output logic [$clog2(N_CBPS)-1:0] wr_addr,
  output logic                      block_done
);

  localparam int ROWS = N_CBPS / N_D;
  localparam int AW   = $clog2(N_CBPS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (N_D > 1) ? $clog2(N_D) : 1;

  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic          last_row;
  logic          last_col;

  assign last_row   = (r == RW'(ROWS - 1));
  assign last_col   = (c == CW'(N_D - 1));
  assign block_done = advance && last_row && last_col;

  // j = ROWS*c + r is written to k = N_D*r + c, the inverse of the transmit permutation.
  assign wr_addr = AW'(r) * AW'(N_D) + AW'(c);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r <= '0;
      c <= '0;
    end else if (advance) begin
      if (last_row) begin
        r <= '0;
        c <= last_col ? '0 : c + 1'b1;
      end else begin
        r <= r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wimax_deinterleaver.sv
// Ping-pong block deinterleaver: one bank fills in permuted order while the other drains
// sequentially. Handshake: a bit moves on a side only in a cycle where its valid and ready are both high.
module wimax_deinterleaver
  import wimax_deinterleaver_pkg::*;
#(
  parameter int N_CBPS = WIMAX_NCBPS,
  parameter int N_D    = WIMAX_D
) (
  input  logic clk,
  input  logic reset_N,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic data_out,
  output logic valid_out,
  input  logic ready_in
);

  localparam int AW = $clog2(N_CBPS);

  logic [N_CBPS-1:0] bank [2];
  logic [1:0]        full;
  logic              wr_sel;
  logic              rd_sel;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic              in_xfer;
  logic              out_xfer;
  logic              wr_done;
  logic              rd_done;

  assign ready_out = !full[wr_sel];
  assign valid_out = full[rd_sel];
  assign in_xfer   = valid_in && ready_out;
  assign out_xfer  = valid_out && ready_in;
  assign rd_done   = out_xfer && (rd_addr == AW'(N_CBPS - 1));
  assign data_out  = valid_out ? bank[rd_sel][rd_addr] : 1'b0;

  wimax_deint_addr_gen #(
    .N_CBPS (N_CBPS),
    .N_D    (N_D)
  ) u_addr_gen (
    .clk        (clk),
    .reset_N    (reset_N),
    .advance    (in_xfer),
    .wr_addr    (wr_addr),
    .block_done (wr_done)
  );

  // Bank contents carry no reset; a bank is only read after a full block has been written.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      bank[wr_sel][wr_addr] <= data_in;
    end
  end

  // Writer and reader always own different banks, so both flag updates can land together.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      full    <= 2'b00;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      rd_addr <= '0;
    end else begin
      if (wr_done) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (rd_done) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        rd_addr      <= '0;
      end else if (out_xfer) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

endmodule
